// File: rtl/chip8_alu_sequencer.sv
// Chip-8 8XYN sequencer: reads Vx/Vy, drives the external ALU, writes Vx and VF.
// Optional: CHIP8_VF_RESET_QUIRK_EN makes ops 1/2/3 also clear VF.
module chip8_alu_sequencer #(
  parameter int REG_W = 8,
  parameter int ALU_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [3:0]       rf_addr,
  input  logic [REG_W-1:0] rf_rd_data,
  output logic             rf_wr_en,
  output logic [REG_W-1:0] rf_wr_data,
  output logic [ALU_W-1:0] alu_input1,
  output logic [ALU_W-1:0] alu_input2,
  output logic [3:0]       alu_sel,
  input  logic [ALU_W-1:0] alu_out,
  input  logic             alu_carry,
  output logic             done,
  output logic             err
);

  typedef enum logic [3:0] {
    S_IDLE, S_ILL, S_RD_X, S_RD_Y, S_CAP_Y, S_EXEC, S_FLAG, S_WB_X, S_WB_F, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       x_q, x_d, y_q, y_d, n_q, n_d;
  logic             ill_q, ill_d;
  logic [REG_W-1:0] vx_q, vx_d, vy_q, vy_d, res_q, res_d;
  logic             flag_q, flag_d;

  logic             ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic [3:0]       addr_q, addr_d, sel_q, sel_d;
  logic             we_q, we_d;
  logic [REG_W-1:0] wdata_q, wdata_d;
  logic [ALU_W-1:0] in1_q, in1_d, in2_q, in2_d;

  logic unused_alu_hi;
  assign unused_alu_hi = ^alu_out[ALU_W-1:REG_W];

  function automatic logic is_legal_n(input logic [3:0] n);
    return (n <= 4'h7) || (n == 4'hE);
  endfunction

  function automatic logic has_flag_op(input logic [3:0] n);
    return (n == 4'h5) || (n == 4'h6) || (n == 4'h7) || (n == 4'hE);
  endfunction

  function automatic logic writes_vf(input logic [3:0] n);
`ifdef CHIP8_VF_RESET_QUIRK_EN
    return (n == 4'h4) || has_flag_op(n) || (n == 4'h1) || (n == 4'h2) || (n == 4'h3);
`else
    return (n == 4'h4) || has_flag_op(n);
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    ill_d   = ill_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    res_d   = res_q;
    flag_d  = flag_q;

    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          x_d     = instr[11:8];
          y_d     = instr[7:4];
          n_d     = instr[3:0];
          ill_d   = (instr[15:12] != 4'h8) || !is_legal_n(instr[3:0]);
          flag_d  = 1'b0;
          state_d = ill_d ? S_ILL : S_RD_X;
        end
      end
      // Illegal opcodes idle one cycle so err lands two cycles after acceptance.
      S_ILL:   state_d = S_DONE;
      S_RD_X:  state_d = S_RD_Y;
      S_RD_Y: begin
        vx_d    = rf_rd_data;
        state_d = S_CAP_Y;
      end
      S_CAP_Y: begin
        vy_d    = rf_rd_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = alu_out[REG_W-1:0];
        if (n_q == 4'h4) flag_d = alu_carry;
        state_d = has_flag_op(n_q) ? S_FLAG : S_WB_X;
      end
      S_FLAG: begin
        unique case (n_q)
          4'h6:    flag_d = vx_q[0];
          4'hE:    flag_d = vx_q[REG_W-1];
          default: flag_d = ~alu_out[0];
        endcase
        state_d = S_WB_X;
      end
      S_WB_X:  state_d = writes_vf(n_q) ? S_WB_F : S_DONE;
      S_WB_F:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
    err_d   = done_d && ill_d;
    addr_d  = '0;
    we_d    = 1'b0;
    wdata_d = '0;
    sel_d   = '0;
    in1_d   = '0;
    in2_d   = '0;

    unique case (state_d)
      S_RD_X: addr_d = x_d;
      S_RD_Y: addr_d = y_d;
      S_WB_X: begin
        addr_d  = x_d;
        we_d    = 1'b1;
        wdata_d = res_d;
      end
      S_WB_F: begin
        addr_d  = 4'hF;
        we_d    = 1'b1;
        wdata_d = REG_W'(flag_d);
      end
      S_EXEC: begin
        unique case (n_d)
          4'h0: begin sel_d = 4'h1; in2_d = ALU_W'(vy_d); end
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            sel_d = n_d; in1_d = ALU_W'(vx_d); in2_d = ALU_W'(vy_d);
          end
          4'h7: begin sel_d = 4'h5; in1_d = ALU_W'(vy_d); in2_d = ALU_W'(vx_d); end
          4'h6: begin sel_d = 4'h7; in1_d = ALU_W'(vx_d); in2_d = ALU_W'(1); end
          4'hE: begin sel_d = 4'h6; in1_d = ALU_W'(vx_d); in2_d = ALU_W'(1); end
          default: sel_d = '0;
        endcase
      end
      S_FLAG: begin
        unique case (n_d)
          4'h5: begin sel_d = 4'h9; in1_d = ALU_W'(vy_d); in2_d = ALU_W'(vx_d); end
          4'h7: begin sel_d = 4'h9; in1_d = ALU_W'(vx_d); in2_d = ALU_W'(vy_d); end
          4'h6: begin sel_d = 4'hA; in1_d = ALU_W'(vx_d); end
          4'hE: begin sel_d = 4'hB; in1_d = ALU_W'(vx_d); end
          default: sel_d = '0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      ill_q   <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      ill_q   <= ill_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
    end
  end

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rf_addr     = addr_q;
  assign rf_wr_en    = we_q;
  assign rf_wr_data  = wdata_q;
  assign alu_sel     = sel_q;
  assign alu_input1  = in1_q;
  assign alu_input2  = in2_q;

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Bench for chip8_alu_sequencer: behavioural register file and ALU around the DUT,
// results checked against an arithmetic model of the 8XYN instruction set.
module tb_chip8_alu_sequencer;

  typedef logic [7:0] regs_t [16];

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_rd_data;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic [15:0] alu_input1, alu_input2, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_carry;
  logic        done, err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int alu_cnt = 0;

  regs_t       rf;
  logic        tb_we = 1'b0;
  logic [3:0]  tb_addr = '0;
  logic [7:0]  tb_data = '0;

  chip8_alu_sequencer #(.REG_W(8), .ALU_W(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_addr(rf_addr), .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en),
    .rf_wr_data(rf_wr_data), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Register file with synchronous read; the bench preloads through its own port.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_we) rf[tb_addr] <= tb_data;
    else if (rf_wr_en) rf[rf_addr] <= rf_wr_data;
    rf_rd_data <= rf[rf_addr];
    if (rf_wr_en) wr_cnt <= wr_cnt + 1;
    if (alu_sel != 4'h0) alu_cnt <= alu_cnt + 1;
  end

  // Chip-8 ALU behaviour; carry is out of the 8-bit register sum.
  always_comb begin
    logic [8:0] s8;
    s8 = {1'b0, alu_input1[7:0]} + {1'b0, alu_input2[7:0]};
    alu_carry = 1'b0;
    case (alu_sel)
      4'h1: alu_out = alu_input1 | alu_input2;
      4'h2: alu_out = alu_input1 & alu_input2;
      4'h3: alu_out = alu_input1 ^ alu_input2;
      4'h4: begin alu_out = alu_input1 + alu_input2; alu_carry = s8[8]; end
      4'h5: alu_out = alu_input1 - alu_input2;
      4'h6: alu_out = alu_input1 << alu_input2;
      4'h7: alu_out = alu_input1 >> alu_input2;
      4'h9: alu_out = {15'd0, alu_input1 > alu_input2};
      4'hA: alu_out = {15'd0, alu_input1[0]};
      4'hB: alu_out = {15'd0, alu_input1[7]};
      default: alu_out = '0;
    endcase
  end

  function automatic void model(input logic [15:0] ins, input regs_t rin,
                                output regs_t rout, output int lat, output bit e);
    int a, b, r, f;
    bit wf;
    logic [3:0] x, y, n;
    x = ins[11:8]; y = ins[7:4]; n = ins[3:0];
    rout = rin;
    a = int'(rin[x]); b = int'(rin[y]);
    r = 0; f = 0; wf = 1'b1; e = 1'b0;
    case (n)
      4'h0: begin r = b; wf = 1'b0; end
      4'h1: begin r = a | b; wf = 1'b0; end
      4'h2: begin r = a & b; wf = 1'b0; end
      4'h3: begin r = a ^ b; wf = 1'b0; end
      4'h4: begin r = a + b; f = (r > 255) ? 1 : 0; end
      4'h5: begin r = a - b; f = (a >= b) ? 1 : 0; end
      4'h7: begin r = b - a; f = (b >= a) ? 1 : 0; end
      4'h6: begin r = a / 2; f = a % 2; end
      4'hE: begin r = a * 2; f = (a >= 128) ? 1 : 0; end
      default: e = 1'b1;
    endcase
    if (ins[15:12] != 4'h8) e = 1'b1;
`ifdef CHIP8_VF_RESET_QUIRK_EN
    if (n >= 4'h1 && n <= 4'h3) begin wf = 1'b1; f = 0; end
`endif
    if (e) begin
      lat = 2;
      return;
    end
    rout[x] = 8'(r & 255);
    if (wf) rout[15] = 8'(f);
    lat = (n == 4'h0 || !wf) ? 6 : ((n == 4'h4 || n <= 4'h3) ? 7 : 8);
  endfunction

  task automatic load_regs(input regs_t v);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tb_we = 1'b1; tb_addr = 4'(i); tb_data = v[i];
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Offers one instruction; returns acceptance cycle, latency to done (-1 on timeout) and err.
  task automatic run_instr(input logic [15:0] ins, input bit hold,
                           output int t_acc, output int lat, output bit e);
    int g;
    @(negedge clk);
    instr_valid = 1'b1; instr = ins;
    g = 0;
    while (!instr_ready && g < 50) begin @(negedge clk); g++; end
    t_acc = cyc;
    @(posedge clk);
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
    instr = 16'($urandom);
    g = 0;
    while (!done && g < 30) begin @(negedge clk); g++; end
    lat = done ? (cyc - t_acc) : -1;
    e = err;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rf_wr_en !== 1'b0 ||
        rf_addr !== 4'h0 || alu_sel !== 4'h0 || alu_input1 !== 16'h0 ||
        alu_input2 !== 16'h0 || rf_wr_data !== 8'h0) begin
      n_errors++;
      $display("FAIL reset_state: ready=%b done=%b err=%b we=%b addr=%h sel=%h in1=%h in2=%h wd=%h, required ready=1 and all others 0",
               instr_ready, done, err, rf_wr_en, rf_addr, alu_sel, alu_input1, alu_input2, rf_wr_data);
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  vx, vy, vf, ex_x, ex_f;
    int          lat;
  } vec_t;

  task automatic test_plan_vectors();
    vec_t v [6];
    regs_t init;
    int t, lat;
    bit e;
    logic [3:0] x, y;
`ifdef CHIP8_VF_RESET_QUIRK_EN
    v[0] = '{16'h8121, 8'h0F, 8'hF0, 8'h5A, 8'hFF, 8'h00, 7};
`else
    v[0] = '{16'h8121, 8'h0F, 8'hF0, 8'h5A, 8'hFF, 8'h5A, 6};
`endif
    v[1] = '{16'h8344, 8'hC8, 8'h64, 8'h00, 8'h2C, 8'h01, 7};
    v[2] = '{16'h8344, 8'hC8, 8'h10, 8'h07, 8'hD8, 8'h00, 7};
    v[3] = '{16'h8565, 8'h20, 8'h20, 8'h00, 8'h00, 8'h01, 8};
    v[4] = '{16'h8565, 8'h10, 8'h20, 8'h33, 8'hF0, 8'h00, 8};
    v[5] = '{16'h8F0E, 8'h81, 8'h00, 8'h81, 8'h01, 8'h01, 8};
    foreach (v[k]) begin
      x = v[k].ins[11:8]; y = v[k].ins[7:4];
      foreach (init[i]) init[i] = 8'(i * 17);
      init[15] = v[k].vf; init[y] = v[k].vy; init[x] = v[k].vx;
      load_regs(init);
      run_instr(v[k].ins, 1'b0, t, lat, e);
      n_checks++;
      if (rf[x] !== v[k].ex_x || rf[15] !== v[k].ex_f) begin
        n_errors++;
        $display("FAIL plan_%0d_result: V%h=%h VF=%h, required V%h=%h VF=%h",
                 k, x, rf[x], rf[15], x, v[k].ex_x, v[k].ex_f);
      end
      n_checks++;
      if (lat !== v[k].lat || e !== 1'b0) begin
        n_errors++;
        $display("FAIL plan_%0d_timing: latency=%0d err=%b, required latency=%0d err=0",
                 k, lat, e, v[k].lat);
      end
    end
  endtask

  task automatic test_random_ops();
    logic [3:0] ops [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
    regs_t init, exp;
    logic [15:0] ins;
    int t, lat, exp_lat;
    bit e, exp_e;
    for (int k = 0; k < 40; k++) begin
      foreach (init[i]) init[i] = 8'($urandom);
      ins = {4'h8, 4'($urandom), 4'($urandom), ops[$urandom_range(0, 8)]};
      if (k < 4) ins[7:4] = ins[11:8];
      model(ins, init, exp, exp_lat, exp_e);
      load_regs(init);
      run_instr(ins, 1'b0, t, lat, e);
      n_checks++;
      if (rf !== exp) begin
        n_errors++;
        $display("FAIL random_regs instr=%h: V%h=%h VF=%h, required V%h=%h VF=%h",
                 ins, ins[11:8], rf[ins[11:8]], rf[15], ins[11:8], exp[ins[11:8]], exp[15]);
      end
      n_checks++;
      if (lat !== exp_lat || e !== exp_e) begin
        n_errors++;
        $display("FAIL random_timing instr=%h: latency=%0d err=%b, required latency=%0d err=%b",
                 ins, lat, e, exp_lat, exp_e);
      end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] list [5];
    regs_t init;
    int t, lat, w0, a0;
    bit e;
    list[0] = 16'h812A;
    list[1] = 16'h9120;
    list[2] = {4'h8, 8'($urandom), 4'hF};
    list[3] = {4'($urandom_range(9, 15)), 8'($urandom), 4'h4};
    list[4] = {4'h8, 8'($urandom), 4'($urandom_range(8, 13))};
    foreach (init[i]) init[i] = 8'($urandom);
    load_regs(init);
    foreach (list[k]) begin
      w0 = wr_cnt; a0 = alu_cnt;
      run_instr(list[k], 1'b0, t, lat, e);
      @(negedge clk);
      n_checks++;
      if (lat !== 2 || e !== 1'b1) begin
        n_errors++;
        $display("FAIL illegal_%h: latency=%0d err=%b, required latency=2 err=1", list[k], lat, e);
      end
      n_checks++;
      if (wr_cnt !== w0 || alu_cnt !== a0 || rf !== init) begin
        n_errors++;
        $display("FAIL illegal_%h_activity: writes=%0d alu_cycles=%0d, required 0 and 0 with regs unchanged",
                 list[k], wr_cnt - w0, alu_cnt - a0);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    regs_t init;
    int w0, g, dones;
    foreach (init[i]) init[i] = 8'(8'h40 + i);
    init[1] = 8'hC8; init[2] = 8'h64; init[15] = 8'h5A;
    load_regs(init);
    @(negedge clk);
    instr_valid = 1'b1; instr = 16'h8124;
    g = 0;
    while (!instr_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (alu_sel !== 4'h4) begin
      n_errors++;
      $display("FAIL reset_mid_exec_reach: alu_sel=%h, required 4 in EXEC", alu_sel);
    end
    w0 = wr_cnt;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (instr_ready !== 1'b1 || rf_wr_en !== 1'b0 || done !== 1'b0 || alu_sel !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_mid_exec_idle: ready=%b we=%b done=%b sel=%h, required 1 0 0 0",
               instr_ready, rf_wr_en, done, alu_sel);
    end
    dones = 0;
    repeat (10) begin @(negedge clk); if (done) dones++; end
    n_checks++;
    if (wr_cnt !== w0 || rf[1] !== 8'hC8 || rf[15] !== 8'h5A || dones !== 0) begin
      n_errors++;
      $display("FAIL reset_mid_exec_nowrite: writes=%0d V1=%h VF=%h dones=%0d, required 0 C8 5A 0",
               wr_cnt - w0, rf[1], rf[15], dones);
    end
  endtask

  task automatic test_back_to_back();
    regs_t init, exp1, exp2;
    int t1, l1, t2, l2, el1, el2, done_cyc;
    bit e1, e2, ee1, ee2;
    foreach (init[i]) init[i] = 8'($urandom);
    model(16'h8234, init, exp1, el1, ee1);
    model(16'h8525, exp1, exp2, el2, ee2);
    load_regs(init);
    run_instr(16'h8234, 1'b1, t1, l1, e1);
    done_cyc = cyc;
    run_instr(16'h8525, 1'b0, t2, l2, e2);
    n_checks++;
    if (t2 !== done_cyc + 1) begin
      n_errors++;
      $display("FAIL back_to_back_accept: accepted %0d cycles after done, required 1", t2 - done_cyc);
    end
    n_checks++;
    if (l1 !== el1 || l2 !== el2 || e1 !== 1'b0 || e2 !== 1'b0) begin
      n_errors++;
      $display("FAIL back_to_back_timing: lat=%0d/%0d err=%b/%b, required %0d/%0d 0/0",
               l1, l2, e1, e2, el1, el2);
    end
    n_checks++;
    if (rf !== exp2) begin
      n_errors++;
      $display("FAIL back_to_back_regs: V2=%h V5=%h VF=%h, required V2=%h V5=%h VF=%h",
               rf[2], rf[5], rf[15], exp2[2], exp2[5], exp2[15]);
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_illegal();
    test_random_ops();
    test_reset_mid_exec();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
